// File: rtl/sfp_acc_pkg.sv
// Shared types and constants for the sfp_acc_bank accumulator bank.
// Holds the FSM encoding, the pass-counter width and the lane saturation limits.
package sfp_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DRAIN,
        ST_FIN
    } state_t;

    localparam int PASS_W = 8;

    // Signed limits of a bw-bit lane, used by the saturating adder.
    function automatic longint sat_max(input int bw);
        return (longint'(1) <<< (bw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int bw);
        return -(longint'(1) <<< (bw - 1));
    endfunction

endpackage

// File: rtl/sfp_acc_bank_lane.sv
// sfp_lane: next stored value for one channel (overwrite, wrap add or saturating add).
// Saturation is selected by defining SFP_ACC_SAT_EN; otherwise adds wrap around.
module sfp_lane
    import sfp_acc_pkg::*;
#(
    parameter int psum_bw = 16
) (
    input  logic [psum_bw-1:0] beat,
    input  logic [psum_bw-1:0] stored,
    input  logic               first,
    output logic [psum_bw-1:0] result
);

`ifdef SFP_ACC_SAT_EN
    localparam logic [psum_bw-1:0] LANE_MAX = psum_bw'(sat_max(psum_bw));
    localparam logic [psum_bw-1:0] LANE_MIN = psum_bw'(sat_min(psum_bw));

    logic [psum_bw:0] sum;

    // One guard bit: overflow shows as the top two sum bits disagreeing.
    assign sum = {stored[psum_bw-1], stored} + {beat[psum_bw-1], beat};

    always_comb begin
        if (first) begin
            result = beat;
        end else if (sum[psum_bw] != sum[psum_bw-1]) begin
            result = sum[psum_bw] ? LANE_MIN : LANE_MAX;
        end else begin
            result = sum[psum_bw-1:0];
        end
    end
`else
    assign result = first ? beat : stored + beat;
`endif

endmodule

// File: rtl/sfp_acc_bank.sv
// sfp_acc_bank: per-channel multi-entry, multi-pass partial-sum accumulator with ReLU drain.
// Lane adds saturate when SFP_ACC_SAT_EN is defined and wrap otherwise.
module sfp_acc_bank
    import sfp_acc_pkg::*;
#(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [$clog2(depth+1)-1:0]  cfg_len,
    input  logic [PASS_W-1:0]           cfg_passes,
    input  logic                        relu,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [psum_bw*col-1:0]      in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [psum_bw*col-1:0]      out,
    output logic                        busy,
    output logic                        done
);

    localparam int LEN_W = $clog2(depth + 1);
    localparam int PTR_W = $clog2(depth);
    localparam int ROW_W = psum_bw * col;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wp_q, rp_q;
    logic [PASS_W-1:0]   pc_q;
    logic [LEN_W-1:0]    len_q, len_c, last_idx;
    logic [PASS_W-1:0]   passes_q;
    logic                relu_q;
    logic [ROW_W-1:0]    mem [depth];
    logic [ROW_W-1:0]    rd_row, next_row, drain_row;
    logic                wp_last, rp_last, pc_last, beat, drain_hs;

    assign len_c    = (cfg_len > LEN_W'(depth)) ? LEN_W'(depth) : cfg_len;
    assign last_idx = len_q - 1'b1;
    assign wp_last  = (LEN_W'(wp_q) == last_idx);
    assign rp_last  = (LEN_W'(rp_q) == last_idx);
    assign pc_last  = (pc_q == passes_q - 1'b1);
    assign beat     = in_valid && in_ready;
    assign drain_hs = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = (cfg_len == '0 || cfg_passes == '0) ? ST_FIN : ST_ACC;
                end
            end
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid && wp_last && pc_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && rp_last) state_d = ST_FIN;
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_row = mem[wp_q];

    for (genvar g = 0; g < col; g++) begin : g_lane
        sfp_lane #(.psum_bw(psum_bw)) u_lane (
            .beat   (in[g*psum_bw +: psum_bw]),
            .stored (rd_row[g*psum_bw +: psum_bw]),
            .first  (pc_q == '0),
            .result (next_row[g*psum_bw +: psum_bw])
        );
    end

    // NOTE: the entry array is reset on purpose: drained values must read 0 after reset,
    // so it is a register file rather than an inferred RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q     <= '0;
            rp_q     <= '0;
            pc_q     <= '0;
            len_q    <= '0;
            passes_q <= '0;
            relu_q   <= 1'b0;
            for (int i = 0; i < depth; i++) mem[i] <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every read sees pre-edge values.
            if (state_q == ST_IDLE && start) begin
                len_q    <= len_c;
                passes_q <= cfg_passes;
                relu_q   <= relu;
                wp_q     <= '0;
                rp_q     <= '0;
                pc_q     <= '0;
            end
            if (beat) begin
                mem[wp_q] <= next_row;
                if (wp_last) begin
                    wp_q <= '0;
                    pc_q <= pc_q + 1'b1;
                end else begin
                    wp_q <= wp_q + 1'b1;
                end
            end
            if (drain_hs) begin
                rp_q <= rp_last ? '0 : rp_q + 1'b1;
            end
        end
    end

    assign drain_row = mem[rp_q];

    always_comb begin
        out = drain_row;
        if (relu_q) begin
            for (int i = 0; i < col; i++) begin
                if (drain_row[i*psum_bw + psum_bw - 1]) out[i*psum_bw +: psum_bw] = '0;
            end
        end
    end

endmodule
